// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment display driver.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
    localparam int unsigned BUS_W      = NUM_DIGITS * DIGIT_W;

    typedef logic [6:0] seg_t;

    // Segment order is {a,b,c,d,e,f,g}, active-low.
    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_DASH  = 7'b1111110;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_st_e;

endpackage

// File: rtl/seg_scan_mux_if.sv
// Digit data in, shared segment bus and digit enables out.
interface seg_scan_mux_if;
    import seg_pkg::*;

    logic                  upd;
    logic [BUS_W-1:0]      digits_in;
    logic [NUM_DIGITS-1:0] dp_in;
    logic [NUM_DIGITS-1:0] blink_mask;
    logic                  lz_blank;
    seg_t                  seg;
    logic                  dp;
    logic [NUM_DIGITS-1:0] an;

    modport master (
        output upd, digits_in, dp_in, blink_mask, lz_blank,
        input  seg, dp, an
    );

    modport slave (
        input  upd, digits_in, dp_in, blink_mask, lz_blank,
        output seg, dp, an
    );

endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes show a dash.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd,
    output seg_t               seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        case (bcd)
            4'd0: seg_c = 7'b0000001;
            4'd1: seg_c = 7'b1001111;
            4'd2: seg_c = 7'b0010010;
            4'd3: seg_c = 7'b0000110;
            4'd4: seg_c = 7'b1001100;
            4'd5: seg_c = 7'b0100100;
            4'd6: seg_c = 7'b0100000;
            4'd7: seg_c = 7'b0001111;
            4'd8: seg_c = 7'b0000000;
            4'd9: seg_c = 7'b0000100;
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Six-digit time-multiplexed display scanner with ghost blanking, leading-zero
// suppression and per-digit blink.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned FRAME_HZ     = 1000,
    parameter int unsigned BLANK_CYC    = 64,
    parameter int unsigned BLINK_FRAMES = 500
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_mux_if.slave  bus
);

    localparam int unsigned SLOT_CYC = CLK_HZ / (FRAME_HZ * NUM_DIGITS);
    localparam int unsigned SLOT_W   = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int unsigned FRAME_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BUS_W-1:0]      shadow_dig_q, shadow_dig_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q,  shadow_dp_d;
    scan_st_e              state_q,      state_d;
    logic [SLOT_W-1:0]     slot_cnt_q,   slot_cnt_d;
    logic [IDX_W-1:0]      idx_q,        idx_d;
    logic [FRAME_W-1:0]    frame_cnt_q,  frame_cnt_d;
    logic                  blink_ph_q,   blink_ph_d;
    logic [DIGIT_W-1:0]    nib_q,        nib_d;
    logic                  dp_bit_q,     dp_bit_d;
    seg_t                  seg_q,        seg_d;
    logic                  dp_q,         dp_d;
    logic [NUM_DIGITS-1:0] an_q,         an_d;

    seg_t dec_seg_c;
    logic slot_end_c;
    logic blank_end_c;
    logic last_idx_c;
    logic suppress_c;

    bcd_to_seg u_dec (
        .bcd   (nib_q),
        .seg_c (dec_seg_c)
    );

    // One counter spans the whole slot; the blank phase ends part-way through it.
    assign slot_end_c  = (slot_cnt_q == SLOT_W'(SLOT_CYC - 1));
    assign blank_end_c = (slot_cnt_q == SLOT_W'(BLANK_CYC - 1));
    assign last_idx_c  = (idx_q == IDX_W'(NUM_DIGITS - 1));

    always_comb begin
        shadow_dig_d = shadow_dig_q;
        shadow_dp_d  = shadow_dp_q;
        state_d      = state_q;
        idx_d        = idx_q;
        frame_cnt_d  = frame_cnt_q;
        blink_ph_d   = blink_ph_q;
        nib_d        = nib_q;
        dp_bit_d     = dp_bit_q;
        seg_d        = SEG_BLANK;
        dp_d         = 1'b1;
        an_d         = '1;
        suppress_c   = 1'b0;

        if (bus.upd) begin
            shadow_dig_d = bus.digits_in;
            shadow_dp_d  = bus.dp_in;
        end

        slot_cnt_d = slot_end_c ? '0 : slot_cnt_q + SLOT_W'(1);

        case (state_q)
            BLANK: begin
                // Latch from the pre-update shadow so an upd this cycle lands next slot.
                if (blank_end_c) begin
                    state_d  = ON;
                    nib_d    = shadow_dig_q[{idx_q, 2'b00} +: DIGIT_W];
                    dp_bit_d = shadow_dp_q[idx_q];
                end
            end
            ON: begin
                if (slot_end_c) begin
                    state_d = BLANK;
                    if (last_idx_c) begin
                        idx_d = '0;
                        if (frame_cnt_q == FRAME_W'(BLINK_FRAMES - 1)) begin
                            frame_cnt_d = '0;
                            blink_ph_d  = ~blink_ph_q;
                        end else begin
                            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
        endcase

        // Blink and leading-zero controls are live, so they act within a cycle.
        suppress_c = (bus.blink_mask[idx_q] && blink_ph_q) ||
                     (last_idx_c && bus.lz_blank && (nib_q == DIGIT_W'(0)));

        if ((state_q == ON) && !suppress_c) begin
            seg_d        = dec_seg_c;
            dp_d         = ~dp_bit_q;
            an_d[idx_q]  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_dig_q <= '0;
            shadow_dp_q  <= '0;
            state_q      <= BLANK;
            slot_cnt_q   <= '0;
            idx_q        <= '0;
            frame_cnt_q  <= '0;
            blink_ph_q   <= 1'b0;
            nib_q        <= '0;
            dp_bit_q     <= 1'b0;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            an_q         <= '1;
        end else begin
            shadow_dig_q <= shadow_dig_d;
            shadow_dp_q  <= shadow_dp_d;
            state_q      <= state_d;
            slot_cnt_q   <= slot_cnt_d;
            idx_q        <= idx_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_ph_q   <= blink_ph_d;
            nib_q        <= nib_d;
            dp_bit_q     <= dp_bit_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
    assign bus.an  = an_q;

endmodule
